// File: rtl/distance_moving_average.sv
// distance_moving_average
// Clamps qualified raw distance samples (units 10^-2 cm) and keeps a
// power-of-two moving average over the last DEPTH accepted samples. The
// registered average feeds the distance-to-duty-cycle PWM converter.
//
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   enable         1 = accept samples, 0 = ignore samples and hold state
//   clear          synchronous flush of window, sum, pointer and outputs
//   sample_in      raw distance sample
//   sample_valid   sample_in valid this cycle
//   distance       averaged distance (registered)
//   distance_valid one-cycle pulse, distance updated this cycle
//   primed         high once DEPTH samples accepted since reset/clear
module distance_moving_average #(
    parameter int unsigned WIDTH        = 13,
    parameter int unsigned LOG2_DEPTH   = 4,
    parameter int unsigned MAX_DISTANCE = 3000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] distance,
    output logic             distance_valid,
    output logic             primed
);

    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;
    localparam int unsigned SUM_W = WIDTH + LOG2_DEPTH;
    localparam int unsigned CNT_W = LOG2_DEPTH + 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]            state;
    logic [0:0]            state_d;
    logic [CNT_W-1:0]      fill_cnt;
    logic [CNT_W-1:0]      fill_cnt_d;
    logic [SUM_W-1:0]      sum;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [WIDTH-1:0]      win [DEPTH];

    logic                  accept_c;
    logic [WIDTH-1:0]      sample_clamped_c;
    logic [SUM_W-1:0]      sum_next_c;

    // Accept qualification; clear wins over a simultaneous sample.
    assign accept_c = enable & sample_valid & ~clear;

    assign sample_clamped_c = (sample_in > WIDTH'(MAX_DISTANCE)) ? WIDTH'(MAX_DISTANCE)
                                                                 : sample_in;

    // Oldest sample leaves as the new one enters; the sum is bounded by
    // DEPTH * MAX_DISTANCE so it cannot wrap in either direction.
    assign sum_next_c = sum + SUM_W'(sample_clamped_c) - SUM_W'(win[wr_ptr]);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_FILL;
            fill_cnt <= '0;
        end else begin
            state    <= state_d;
            fill_cnt <= fill_cnt_d;
        end
    end

    // FSM next state: count accepts while filling, freeze once running.
    always_comb begin
        state_d    = state;
        fill_cnt_d = fill_cnt;
        if (clear) begin
            state_d    = ST_FILL;
            fill_cnt_d = '0;
        end else if (accept_c) begin
            case (state)
                ST_FILL: begin
                    fill_cnt_d = fill_cnt + CNT_W'(1);
                    if (fill_cnt == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Window, running sum and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            sum            <= '0;
            wr_ptr         <= '0;
            distance       <= '0;
            distance_valid <= 1'b0;
            primed         <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win[i] <= '0;
            end
            sum            <= '0;
            wr_ptr         <= '0;
            distance       <= '0;
            distance_valid <= 1'b0;
            primed         <= 1'b0;
        end else begin
            distance_valid <= 1'b0;
            primed         <= (state_d == ST_RUN);
            if (accept_c) begin
                win[wr_ptr]    <= sample_clamped_c;
                sum            <= sum_next_c;
                wr_ptr         <= wr_ptr + LOG2_DEPTH'(1);
                distance       <= sum_next_c[SUM_W-1:LOG2_DEPTH];
                distance_valid <= 1'b1;
            end
        end
    end

endmodule
